// File: rtl/adc_delay_calib_if.sv
// Delay-tap control bus between the calibration engine and the ADC
// interface delay port.
//   master : calibration engine (drives tap, line select, load strobe)
//   slave  : ADC interface (returns ready level and read-back tap)
// Signals:
//   delay_reg      tap value to load
//   delay_select   line select (bit 16 = OV line, 15:0 = data lines)
//   delay_load     one-cycle load strobe
//   delay_rdy      delay-ready level from the ADC interface
//   delay_reg_read tap value read back from the ADC interface
interface adc_delay_calib_if;
    logic [4:0]  delay_reg;
    logic [16:0] delay_select;
    logic        delay_load;
    logic        delay_rdy;
    logic [4:0]  delay_reg_read;

    modport master (
        output delay_reg, delay_select, delay_load,
        input  delay_rdy, delay_reg_read
    );

    modport slave (
        input  delay_reg, delay_select, delay_load,
        output delay_rdy, delay_reg_read
    );
endinterface

// File: rtl/adc_delay_calib.sv
// ADC input-delay calibration engine. Sweeps all 32 delay taps, checks the
// ADC test pattern at each tap, finds the widest run of passing taps and
// finally loads the centre of that run.
// Ports:
//   sys_clk        sole clock, rising edge
//   rst_n          synchronous active-low reset
//   start          single-cycle sweep request (ignored while busy)
//   pattern        expected test-pattern word, stable while busy
//   adc_data       ADC samples (sys_clk domain)
//   adc_data_valid qualifies adc_data
//   dly            delay-port bus (master side)
//   busy           sweep in progress
//   done           one-cycle pulse on successful completion
//   fail           level, set on a failed sweep until the next start
//   best_tap       tap finally loaded
//   window_len     width of the widest passing window (0-32)
module adc_delay_calib #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CHECK_SAMPLES = 64,
    parameter int unsigned RDY_TIMEOUT   = 255,
    parameter logic [16:0] SELECT_MASK   = 17'h1FFFF
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              pattern,
    input  logic [15:0]              adc_data,
    input  logic                     adc_data_valid,
    adc_delay_calib_if.master        dly,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [4:0]               best_tap,
    output logic [5:0]               window_len
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_SAMPLES - 1);
    localparam logic [15:0] RDY_LAST    = 16'(RDY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_RDY, SETTLE, CHECK, NEXT, FINAL_LOAD, FINAL_WAIT, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [4:0]  tap;
    logic [16:0] sel;
    logic        pass;
    logic [5:0]  run_len, best_len;
    logic [4:0]  run_start, best_start;

    logic        confirm, rdy_expired, settle_end, sample_hit, sample_miss, check_end;
    logic        last_tap;
    logic [5:0]  close_len, new_best_len;
    logic [4:0]  close_start, new_best_start, half, centre;

    assign dly.delay_reg    = tap;
    assign dly.delay_select = sel;

    // A load is confirmed only when the interface is ready AND reports the tap we asked for.
    assign confirm     = dly.delay_rdy && (dly.delay_reg_read == tap);
    // cnt is 0 on the first cycle after the strobe, so RDY_LAST marks the RDY_TIMEOUT-th wait cycle.
    assign rdy_expired = !confirm && (cnt == RDY_LAST);
    assign settle_end  = (cnt == SETTLE_LAST);
    assign sample_hit  = adc_data_valid && (adc_data == pattern);
    assign sample_miss = adc_data_valid && (adc_data != pattern);
    assign check_end   = sample_miss || (sample_hit && (cnt == CHECK_LAST));

    // Run tracking for the NEXT state: the run including this tap (if it
    // passed) is closed on a failing tap or after the last tap. Strict '>'
    // keeps the earlier run on equal length.
    always_comb begin
        last_tap       = (tap == 5'd31);
        close_len      = pass ? run_len + 6'd1 : run_len;
        close_start    = (pass && (run_len == 6'd0)) ? tap : run_start;
        new_best_len   = best_len;
        new_best_start = best_start;
        if ((!pass || last_tap) && (close_len > best_len)) begin
            new_best_len   = close_len;
            new_best_start = close_start;
        end
        half   = 5'((new_best_len - 6'd1) >> 1);
        centre = new_best_start + half;
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = LOAD;
            LOAD:       state_nxt = WAIT_RDY;
            WAIT_RDY:   if (confirm) state_nxt = SETTLE;
                        else if (rdy_expired) state_nxt = FINAL_LOAD;
            SETTLE:     if (settle_end) state_nxt = CHECK;
            CHECK:      if (check_end) state_nxt = NEXT;
            NEXT:       state_nxt = last_tap ? FINAL_LOAD : LOAD;
            FINAL_LOAD: state_nxt = FINAL_WAIT;
            FINAL_WAIT: if (confirm || rdy_expired) state_nxt = FINISH;
            FINISH:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        dly.delay_load = (state == LOAD) || (state == FINAL_LOAD);
        done           = (state == FINISH) && !fail;
    end

    // Datapath: tap, counters, run trackers and status registers
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            tap        <= '0;
            sel        <= '0;
            pass       <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            busy       <= 1'b0;
            fail       <= 1'b0;
            best_tap   <= '0;
            window_len <= '0;
        end else begin
            // One shared counter: cleared on every state change.
            if (state_nxt != state)
                cnt <= '0;
            else if ((state == WAIT_RDY) || (state == FINAL_WAIT) || (state == SETTLE) ||
                     ((state == CHECK) && sample_hit))
                cnt <= cnt + 16'd1;

            case (state)
                IDLE: if (start) begin
                    tap        <= '0;
                    sel        <= SELECT_MASK;
                    run_len    <= '0;
                    run_start  <= '0;
                    best_len   <= '0;
                    best_start <= '0;
                    fail       <= 1'b0;
                    busy       <= 1'b1;
                end
                WAIT_RDY: if (rdy_expired) begin
                    // Abandon the sweep and park the line at tap 0.
                    fail <= 1'b1;
                    busy <= 1'b0;
                    tap  <= '0;
                end
                CHECK: if (check_end) pass <= !sample_miss;
                NEXT: begin
                    if (pass) begin
                        run_len   <= close_len;
                        run_start <= close_start;
                    end else begin
                        run_len   <= '0;
                    end
                    best_len   <= new_best_len;
                    best_start <= new_best_start;
                    if (!last_tap) begin
                        tap <= tap + 5'd1;
                    end else if (new_best_len == 6'd0) begin
                        tap  <= '0;
                        fail <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        tap <= centre;
                    end
                end
                FINAL_WAIT: if (confirm || rdy_expired) begin
                    busy       <= 1'b0;
                    best_tap   <= tap;
                    window_len <= (fail || rdy_expired) ? 6'd0 : best_len;
                    if (rdy_expired) fail <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_delay_calib.sv
// Testbench for adc_delay_calib: directed sweeps against a run-scanning
// reference model, with an ADC-interface responder and a per-cycle checker.
module tb_adc_delay_calib;

    localparam int          SETTLE  = 4;
    localparam int          CHECKN  = 8;
    localparam int          TO      = 20;
    localparam int          RDY_LAT = 3;
    localparam logic [16:0] MASK    = 17'h1FFFF;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] pattern = 16'hA5C3;
    logic [15:0] adc_data = 16'h0000;
    logic        adc_data_valid = 1'b0;
    logic        busy, done, fail;
    logic [4:0]  best_tap;
    logic [5:0]  window_len;

    adc_delay_calib_if dly();

    adc_delay_calib #(
        .SETTLE_CYCLES(SETTLE),
        .CHECK_SAMPLES(CHECKN),
        .RDY_TIMEOUT  (TO),
        .SELECT_MASK  (MASK)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .start         (start),
        .pattern       (pattern),
        .adc_data      (adc_data),
        .adc_data_valid(adc_data_valid),
        .dly           (dly),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .best_tap      (best_tap),
        .window_len    (window_len)
    );

    always #5 sys_clk = ~sys_clk;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] passmask = 32'h0;
    int          vperiod = 1;
    bit          rdy_en  = 1'b1;
    logic [4:0]  applied = 5'd0;
    int          lat  = 0;
    int          vcnt = 0;
    logic [4:0]  exp_q[$];
    bit          chk_on = 1'b0;
    logic [4:0]  exp_best = 5'd0;
    logic [5:0]  exp_win  = 6'd0;
    bit          exp_fail = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: scan every start position for the longest run of passing
    // taps; only a strictly longer run replaces the current best.
    task automatic model(input logic [31:0] pm, output logic [4:0] bt,
                         output logic [5:0] wl, output bit f);
        int best = 0;
        int bs   = 0;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while ((s + l < 32) && pm[s + l]) l++;
            if (l > best) begin
                best = l;
                bs   = s;
            end
        end
        if (best == 0) begin
            bt = 5'd0; wl = 6'd0; f = 1'b1;
        end else begin
            bt = 5'(bs + (best - 1) / 2); wl = 6'(best); f = 1'b0;
        end
    endtask

    // ADC interface responder: confirms a load RDY_LAT cycles after the
    // strobe, and streams pattern (passing tap) or its inverse (failing tap).
    initial begin
        dly.delay_rdy      = 1'b0;
        dly.delay_reg_read = 5'd0;
        forever begin
            @(negedge sys_clk);
            if (dly.delay_load) begin
                applied       = dly.delay_reg;
                lat           = RDY_LAT;
                dly.delay_rdy = 1'b0;
            end else if (lat > 0) begin
                lat--;
                if ((lat == 0) && rdy_en) begin
                    dly.delay_rdy      = 1'b1;
                    dly.delay_reg_read = applied;
                end
            end
            vcnt           = (vcnt + 1) % vperiod;
            adc_data_valid = (vcnt == 0);
            adc_data       = passmask[applied] ? pattern : ~pattern;
        end
    end

    // Per-cycle checker: every strobe must carry the next expected tap,
    // and a done pulse must carry the model's result.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_on) begin
                if (dly.delay_load) begin
                    chk("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("strobe_tap", dly.delay_reg, exp_q.pop_front());
                    chk("strobe_select", dly.delay_select, MASK);
                end
                if (done) begin
                    chk("done_allowed", exp_fail, 0);
                    chk("done_best_tap", best_tap, exp_best);
                    chk("done_window_len", window_len, exp_win);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge sys_clk); start = 1'b1;
        @(negedge sys_clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("fail_cleared_on_start", fail, 0);
    endtask

    task automatic sweep(input logic [31:0] pm, input int vp, input bit midstart);
        int n = 0;
        passmask = pm;
        vperiod  = vp;
        model(pm, exp_best, exp_win, exp_fail);
        exp_q.delete();
        for (int t = 0; t < 32; t++) exp_q.push_back(5'(t));
        exp_q.push_back(exp_best);
        pulse_start();
        while (!(done || fail) && (n < 5000)) begin
            @(negedge sys_clk);
            n++;
            start = (midstart && (n == 200));
        end
        start = 1'b0;
        chk("sweep_completes", n < 5000, 1);
        if (done) begin
            chk("busy_at_done", busy, 0);
            chk("fail_at_done", fail, 0);
            @(negedge sys_clk);
            chk("done_one_cycle", done, 0);
        end else begin
            chk("busy_at_fail", busy, 0);
            repeat (3 * TO) @(negedge sys_clk);
            chk("fail_level_held", fail, 1);
            chk("fail_window_len", window_len, 0);
            chk("fail_best_tap", best_tap, 0);
            chk("fail_delay_reg", dly.delay_reg, 0);
        end
        chk("all_strobes_seen", exp_q.size(), 0);
    endtask

    initial begin
        logic [4:0] mb;
        logic [5:0] mw;
        bit         mf;
        int         k;

        // Pin the reference model with hand-computed results.
        model(32'h001FFC00, mb, mw, mf);
        chk("model_10_20_tap", mb, 15); chk("model_10_20_win", mw, 11); chk("model_10_20_fail", mf, 0);
        model(32'h00F0003C, mb, mw, mf);
        chk("model_tie_tap", mb, 3); chk("model_tie_win", mw, 4);
        model(32'h00000000, mb, mw, mf);
        chk("model_none_fail", mf, 1); chk("model_none_win", mw, 0);
        model(32'hFFFFFFFF, mb, mw, mf);
        chk("model_all_tap", mb, 15); chk("model_all_win", mw, 32);

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fail", fail, 0);
        chk("rst_delay_reg", dly.delay_reg, 0); chk("rst_select", dly.delay_select, 0);
        chk("rst_load", dly.delay_load, 0); chk("rst_best_tap", best_tap, 0);
        chk("rst_window_len", window_len, 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Taps 10..20 pass
        sweep(32'h001FFC00, 1, 1'b0);
        chk("r10_20_best_tap", best_tap, 15); chk("r10_20_window_len", window_len, 11);

        // Two equal runs: earlier wins
        sweep(32'h00F0003C, 1, 1'b0);
        chk("tie_best_tap", best_tap, 3); chk("tie_window_len", window_len, 4);

        // All taps fail
        sweep(32'h00000000, 1, 1'b0);
        chk("none_fail", fail, 1); chk("none_window_len", window_len, 0);

        // All taps pass, sparse valid, stray start mid-sweep
        sweep(32'hFFFFFFFF, 3, 1'b1);
        chk("all_best_tap", best_tap, 15); chk("all_window_len", window_len, 32);
        chk("all_final_delay_reg", dly.delay_reg, 15);

        // Ready never returns after the first strobe
        rdy_en   = 1'b0;
        passmask = 32'hFFFFFFFF;
        vperiod  = 1;
        exp_fail = 1'b1;
        exp_q.delete();
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd0);
        pulse_start();
        k = 0;
        while (!fail && (k < 200)) begin
            @(negedge sys_clk);
            k++;
        end
        chk("timeout_fail_cycle", k, TO + 1);
        chk("timeout_busy", busy, 0);
        repeat (3 * TO) @(negedge sys_clk);
        chk("timeout_delay_reg", dly.delay_reg, 0);
        chk("timeout_window_len", window_len, 0);
        chk("timeout_strobes", exp_q.size(), 0);
        chk("timeout_fail_level", fail, 1);
        rdy_en = 1'b1;

        // Reset during CHECK at tap 7
        passmask = 32'hFFFFFFFF;
        model(passmask, exp_best, exp_win, exp_fail);
        exp_q.delete();
        for (int t = 0; t < 32; t++) exp_q.push_back(5'(t));
        exp_q.push_back(exp_best);
        pulse_start();
        k = 0;
        while ((exp_q.size() > 25) && (k < 2000)) begin
            @(negedge sys_clk);
            k++;
        end
        chk("reached_tap7", exp_q.size(), 25);
        repeat (10) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        exp_q.delete();
        rst_n = 1'b1;
        chk("mrst_busy", busy, 0); chk("mrst_done", done, 0); chk("mrst_fail", fail, 0);
        chk("mrst_delay_reg", dly.delay_reg, 0); chk("mrst_select", dly.delay_select, 0);
        chk("mrst_load", dly.delay_load, 0); chk("mrst_best_tap", best_tap, 0);
        chk("mrst_window_len", window_len, 0);
        repeat (100) @(negedge sys_clk);
        chk("mrst_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
